// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: stalls the pipeline, issues one data-memory
// request per access, formats load data and reports bus-error on timeout.
//
// state | meaning
// IDLE  | no access in flight; an aligned load/store starts a request
// REQ   | request on the bus, waiting for ack or timeout
// DONE  | result registered, pipeline released for one cycle
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      memread_m,
    input  logic                      memwrite_m,
    input  logic [1:0]                memsize_m,
    input  logic                      memsigned_m,
    input  logic [31:0]               execout_m,
    input  logic [31:0]               writedata_m,
    output logic [31:0]               readdata_m,
    output logic                      stall_m,
    output logic                      misalign_m,
    output logic                      buserr_m,
    mem_access_unit_if.master         dbus
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             access;
    logic             misaligned;
    logic             req;
    logic             ack_hit;
    logic             timeout_hit;
    logic [3:0]       be_raw;
    logic [31:0]      wdata_fmt;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_fmt;

    assign access = memread_m | memwrite_m;

    always_comb begin
        misaligned = 1'b0;
        case (memsize_m)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = execout_m[0];
            default: misaligned = |execout_m[1:0];
        endcase
    end

    assign misalign_m = access & misaligned;

    always_comb begin
        be_raw    = 4'b1111;
        wdata_fmt = writedata_m;
        case (memsize_m)
            2'b00: begin
                be_raw    = 4'b0001 << execout_m[1:0];
                wdata_fmt = {4{writedata_m[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << execout_m[1:0];
                wdata_fmt = {2{writedata_m[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_fmt = writedata_m;
            end
        endcase
    end

    always_comb begin
        ld_byte  = dbus.dmem_rdata[7:0];
        ld_half  = execout_m[1] ? dbus.dmem_rdata[31:16] : dbus.dmem_rdata[15:0];
        load_fmt = dbus.dmem_rdata;
        case (execout_m[1:0])
            2'b00:   ld_byte = dbus.dmem_rdata[7:0];
            2'b01:   ld_byte = dbus.dmem_rdata[15:8];
            2'b10:   ld_byte = dbus.dmem_rdata[23:16];
            default: ld_byte = dbus.dmem_rdata[31:24];
        endcase
        case (memsize_m)
            2'b00:   load_fmt = {{24{memsigned_m & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{16{memsigned_m & ld_half[15]}}, ld_half};
            default: load_fmt = dbus.dmem_rdata;
        endcase
    end

    // Outputs are gated by reset_n so the pipeline is released while reset is held,
    // even if a load/store is still presented in the (forced) IDLE state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_m     = 1'b0;
        req         = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        if (reset_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (access && !misaligned) begin
                        stall_m = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    req     = 1'b1;
                    stall_m = 1'b1;
                    if (dbus.dmem_ack) begin
                        ack_hit = 1'b1;
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_hit = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign dbus.dmem_req   = req;
    assign dbus.dmem_we    = req & memwrite_m;
    assign dbus.dmem_addr  = {execout_m[31:2], 2'b00};
    assign dbus.dmem_be    = req ? be_raw : 4'b0000;
    assign dbus.dmem_wdata = wdata_fmt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            readdata_m <= '0;
            buserr_m   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Stores leave readdata_m alone, including on a store timeout.
            if (ack_hit && memread_m)
                readdata_m <= load_fmt;
            else if (timeout_hit && memread_m)
                readdata_m <= '0;
            if (ack_hit)
                buserr_m <= 1'b0;
            else if (timeout_hit)
                buserr_m <= 1'b1;
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles in REQ awaiting dmem_ack before bus error.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 memread_m  in  1  current MEM-stage instruction is a load.
REQ-005 memwrite_m  in  1  current MEM-stage instruction is a store; never asserted together with memread_m.
REQ-006 memsize_m  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 memsigned_m  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 execout_m  in  32  effective byte address.
REQ-009 writedata_m  in  32  store data, right-aligned.
REQ-010 readdata_m  out  32  formatted load data toward the MEM/WB register.
REQ-011 stall_m  out  1  freeze all stages up to and including MEM.
REQ-012 misalign_m  out  1  combinational misaligned-access flag.
REQ-013 buserr_m  out  1  access ended by timeout; valid in DONE.
REQ-014 dmem_req  out  1  data-memory request.
REQ-015 dmem_we  out  1  1 write, 0 read.
REQ-016 dmem_addr  out  32  word address: execout_m with bits [1:0] forced to 0.
REQ-017 dmem_be  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-018 dmem_wdata  out  32  lane-replicated store data.
REQ-019 dmem_ack  in  1  memory completes the request this cycle.
REQ-020 dmem_rdata  in  32  read word, valid when dmem_ack=1.

Function
REQ-021 Three states: IDLE, REQ, DONE; internal TIMEOUT counter, width ceil(log2(TIMEOUT+1)).
REQ-022 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; misalign_m = (memread_m|memwrite_m) & misaligned, evaluated in every state.
REQ-023 IDLE: if (memread_m|memwrite_m) and not misaligned -> stall_m=1, clear counter, next REQ; otherwise stall_m=0, remain IDLE.
REQ-024 Misaligned access: no request issued, no stall, readdata_m unchanged.
REQ-025 REQ: dmem_req=1, stall_m=1, dmem_we=memwrite_m; dmem_addr, dmem_be and dmem_wdata driven from inputs, which remain stable because the pipeline is stalled.
REQ-026 REQ with dmem_ack=1: for a load, register formatted dmem_rdata into readdata_m; buserr_m<=0; next DONE.
REQ-027 REQ with dmem_ack=0: increment counter; on the cycle counter equals TIMEOUT, deassert request, readdata_m<=0, buserr_m<=1, next DONE.
REQ-028 DONE: stall_m=0, dmem_req=0, next IDLE unconditionally; the pipeline advances at the end of DONE, so the same access is never reissued.
REQ-029 Minimum access latency: 2 stall cycles (IDLE + REQ with same-cycle ack).
REQ-030 Byte enables: byte -> 0001<<addr[1:0]; half -> 0011<<addr[1:0]; word -> 1111; dmem_be=0000 when dmem_req=0.
REQ-031 Store data: byte -> {4{wd[7:0]}}; half -> {2{wd[15:0]}}; word -> wd.
REQ-032 Load data: select lane by addr[1:0] (byte) or addr[1] (half), then extend to 32 bits per memsigned_m; word passes through.
REQ-033 A store never modifies readdata_m.
REQ-034 dmem_ack outside REQ is ignored.

Reset
REQ-035 reset_n=0 asynchronously forces IDLE, counter=0, readdata_m=0, buserr_m=0; dmem_req=0, stall_m=0, dmem_be=0000 while reset_n=0.
REQ-036 Reset asserted in REQ abandons the transaction; dmem_req drops immediately and no data is captured.

Verification
REQ-037 Signed byte load: addr 0x1003, memsigned=1, rdata 0x80FF_FF7F, ack on first REQ cycle -> be=1000, readdata_m=0xFFFF_FF80, stall high exactly 2 cycles.
REQ-038 Half store: addr 0x2002, writedata 0x0000_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, readdata_m unchanged.
REQ-039 Unsigned half load with 3-cycle ack delay: addr 0x0002, rdata 0xA5A5_0000 -> readdata_m=0x0000_A5A5, stall high 5 cycles.
REQ-040 Misaligned word load: addr 0x0001 -> misalign_m=1, dmem_req never asserted, stall_m=0.
REQ-041 TIMEOUT=4, no ack -> dmem_req high 5 cycles, then DONE with buserr_m=1, readdata_m=0, next IDLE.
REQ-042 reset_n pulsed low during second REQ cycle -> dmem_req and stall_m drop immediately; after release, IDLE with all outputs at reset values.
